bb_adc_responder: RTL and testbench

BB_ADC_RESPONDER -- requirements
Module: bb_adc_responder

---
 rtl/bb_adc_pkg.sv | 24 ++
 rtl/bb_adc_shreg.sv | 39 +++
 rtl/bb_adc_responder.sv | 175 +++++++++++++++++
 tb/tb_bb_adc_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bb_adc_pkg.sv
// rtl/bb_adc_pkg.sv - shared state encoding and default constants for the ADC responder
//
// Purpose: one place for the responder FSM encoding and the default
// parameter values, so the top and the readout register agree.
// Ports: none (package).

package bb_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_BUSY  = 2'd2,
    ST_READY = 2'd3
  } state_t;

  localparam int DEF_WIDTH    = 12;
  localparam int DEF_CONV_DLY = 2;
  localparam int DEF_BUSY_LEN = 16;

  // Sized for CONV_DLY <= 15 and BUSY_LEN <= 255.
  localparam int DLY_CNT_W  = 4;
  localparam int BUSY_CNT_W = 8;

endpackage

// File: rtl/bb_adc_shreg.sv
// rtl/bb_adc_shreg.sv - serial result register: parallel load, left shift, MSB out
//
// Purpose: holds a finished conversion result and serialises it MSB first.
// Ports:
//   i_clk   - clock
//   i_rst   - asynchronous active-high reset, clears the register
//   i_load  - parallel load of i_data (wins over i_shift)
//   i_shift - shift left by one, zero fill
//   i_data  - result to load
//   o_msb   - current MSB (a flop output)

module bb_adc_shreg
  import bb_adc_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic             i_shift,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_msb
);

  logic [WIDTH-1:0] r_sr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sr <= '0;
    end else if (i_load) begin
      r_sr <= i_data;
    end else if (i_shift) begin
      r_sr <= {r_sr[WIDTH-2:0], 1'b0};
    end
  end

  assign o_msb = r_sr[WIDTH-1];

endmodule

// File: rtl/bb_adc_responder.sv
// rtl/bb_adc_responder.sv - behavioural ADC responder: start edge, delay, busy window, serial readout
//
// Purpose: answers an ADC controller as a real converter would. A rising
// BBCONV captures SAMPLE, ADCBUSY pulses after a fixed delay, and the
// captured value is then read out serially on SDO under SHIFT.
// Ports:
//   CLK      - clock, all state on the rising edge
//   RST      - asynchronous active-high reset
//   BBCONV   - conversion request level; only its rising edge starts a conversion
//   SAMPLE   - value captured at conversion start
//   SHIFT    - readout strobe, one bit per high cycle while Ready
//   ADCBUSY  - registered busy flag
//   SDO      - registered serial result, MSB first
//   OVR      - sticky: a start arrived while a conversion was in flight
//   CONV_CNT - accepted conversions, wrapping

module bb_adc_responder
  import bb_adc_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CONV_DLY = DEF_CONV_DLY,
  parameter int BUSY_LEN = DEF_BUSY_LEN
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BBCONV,
  input  logic [WIDTH-1:0] SAMPLE,
  input  logic             SHIFT,
  output logic             ADCBUSY,
  output logic             SDO,
  output logic             OVR,
  output logic [7:0]       CONV_CNT
);

  state_t                r_state;
  state_t                w_next_state;
  logic                  r_conv_d;
  logic [DLY_CNT_W-1:0]  r_dly_cnt;
  logic [BUSY_CNT_W-1:0] r_busy_cnt;
  logic [WIDTH-1:0]      r_conv_data;
  logic                  r_adcbusy;
  logic                  r_ovr;
  logic [7:0]            r_conv_cnt;

  logic                  w_start;
  logic                  w_dly_done;
  logic                  w_busy_done;
  logic                  w_accept;
  logic                  w_overrun;
  logic                  w_load;
  logic                  w_shift;
  logic                  w_busy_nxt;
  logic                  w_sdo;

  assign w_start     = BBCONV & ~r_conv_d;
  assign w_dly_done  = (r_dly_cnt == '0);
  assign w_busy_done = (r_busy_cnt == '0);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (w_start)     w_next_state = ST_DELAY;
      ST_DELAY: if (w_dly_done)  w_next_state = ST_BUSY;
      ST_BUSY:  if (w_busy_done) w_next_state = ST_READY;
      ST_READY: if (w_start)     w_next_state = ST_DELAY;
      default:                   w_next_state = ST_IDLE;
    endcase
  end

  // Output / control decode.
  always_comb begin
    w_accept   = 1'b0;
    w_overrun  = 1'b0;
    w_load     = 1'b0;
    w_shift    = 1'b0;
    w_busy_nxt = (w_next_state == ST_BUSY);
    case (r_state)
      ST_IDLE: begin
        w_accept = w_start;
      end
      ST_DELAY: begin
        w_overrun = w_start;
      end
      ST_BUSY: begin
        w_overrun = w_start;
        w_load    = w_busy_done;
      end
      ST_READY: begin
        w_accept = w_start;
        // A start in the same cycle as SHIFT wins; the old result stays put.
        w_shift  = SHIFT & ~w_start;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // The edge detector resets high so a BBCONV already asserted at reset
  // release is not mistaken for a fresh request.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_conv_d <= 1'b1;
    end else begin
      r_conv_d <= BBCONV;
    end
  end

  // Delay counter is loaded with the full CONV_DLY on the start edge and
  // hands over to Busy when it reaches zero, which places the first busy
  // cycle CONV_DLY+1 edges after the start edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_dly_cnt  <= '0;
      r_busy_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_dly_cnt <= DLY_CNT_W'(CONV_DLY);
      end else if (r_state == ST_DELAY && !w_dly_done) begin
        r_dly_cnt <= r_dly_cnt - 1'b1;
      end

      if (r_state == ST_DELAY && w_dly_done) begin
        r_busy_cnt <= BUSY_CNT_W'(BUSY_LEN - 1);
      end else if (r_state == ST_BUSY && !w_busy_done) begin
        r_busy_cnt <= r_busy_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_conv_data <= '0;
      r_conv_cnt  <= '0;
      r_ovr       <= 1'b0;
      r_adcbusy   <= 1'b0;
    end else begin
      r_adcbusy <= w_busy_nxt;
      if (w_accept) begin
        r_conv_data <= SAMPLE;
        r_conv_cnt  <= r_conv_cnt + 8'd1;
        r_ovr       <= 1'b0;
      end else if (w_overrun) begin
        r_ovr <= 1'b1;
      end
    end
  end

  bb_adc_shreg #(
    .WIDTH (WIDTH)
  ) u_shreg (
    .i_clk   (CLK),
    .i_rst   (RST),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (r_conv_data),
    .o_msb   (w_sdo)
  );

  assign ADCBUSY  = r_adcbusy;
  assign SDO      = w_sdo;
  assign OVR      = r_ovr;
  assign CONV_CNT = r_conv_cnt;

endmodule

// File: tb/tb_bb_adc_responder.sv
// tb/tb_bb_adc_responder.sv - scoreboard bench for the ADC responder with a timing-rule reference model

module tb_bb_adc_responder;

  localparam int WIDTH    = 12;
  localparam int CONV_DLY = 2;
  localparam int BUSY_LEN = 16;

  logic             CLK    = 1'b0;
  logic             RST    = 1'b1;
  logic             BBCONV = 1'b0;
  logic             SHIFT  = 1'b0;
  logic [WIDTH-1:0] SAMPLE = '0;
  logic             ADCBUSY;
  logic             SDO;
  logic             OVR;
  logic [7:0]       CONV_CNT;

  bb_adc_responder #(
    .WIDTH    (WIDTH),
    .CONV_DLY (CONV_DLY),
    .BUSY_LEN (BUSY_LEN)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BBCONV   (BBCONV),
    .SAMPLE   (SAMPLE),
    .SHIFT    (SHIFT),
    .ADCBUSY  (ADCBUSY),
    .SDO      (SDO),
    .OVR      (OVR),
    .CONV_CNT (CONV_CNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  typedef struct {
    int               rise;
    int               fall;
    logic [WIDTH-1:0] data;
    logic [7:0]       cnt;
    logic             ovr;
  } exp_t;

  exp_t exp_q[$];
  logic bit_q[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: conversion timing as absolute edge numbers.
  int               m_fall      = -100;
  int               m_load_edge = -100;
  logic             m_pend      = 1'b0;
  logic [WIDTH-1:0] m_pend_data = '0;
  logic [WIDTH-1:0] m_sr        = '0;
  logic [7:0]       m_cnt       = '0;
  logic             m_ovr       = 1'b0;
  logic             m_prev      = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_fall      = -100;
    m_load_edge = -100;
    m_pend      = 1'b0;
    m_pend_data = '0;
    m_sr        = '0;
    m_cnt       = '0;
    m_ovr       = 1'b0;
    m_prev      = 1'b1;
    exp_q.delete();
    bit_q.delete();
  endtask

  // Called just after a rising edge; predicts the effect of the next edge,
  // drives the inputs and advances one cycle.
  task automatic tick(input logic conv, input logic shift, input logic [WIDTH-1:0] smp);
    int   k;
    logic start;
    exp_t e;
    k = cyc;
    if (m_pend && k >= m_load_edge) begin
      m_sr   = m_pend_data;
      m_pend = 1'b0;
    end
    if (shift) bit_q.push_back(m_sr[WIDTH-1]);
    start  = conv && !m_prev;
    m_prev = conv;
    if (start && k >= m_fall) begin
      m_cnt       = m_cnt + 8'd1;
      m_ovr       = 1'b0;
      e.rise      = k + 1 + CONV_DLY + 1;
      e.fall      = e.rise + BUSY_LEN;
      e.data      = smp;
      e.cnt       = m_cnt;
      e.ovr       = 1'b0;
      exp_q.push_back(e);
      m_fall      = e.fall;
      m_load_edge = e.fall;
      m_pend      = 1'b1;
      m_pend_data = smp;
    end else if (start) begin
      m_ovr = 1'b1;
      if (exp_q.size() > 0) begin
        e     = exp_q.pop_back();
        e.ovr = 1'b1;
        exp_q.push_back(e);
      end
    end else if (shift && k >= m_fall) begin
      m_sr = m_sr << 1;
    end
    BBCONV = conv;
    SHIFT  = shift;
    SAMPLE = smp;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, SAMPLE);
  endtask

  task automatic shifts(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b1, SAMPLE);
  endtask

  task automatic do_reset(input logic conv_level);
    RST    = 1'b1;
    BBCONV = conv_level;
    SHIFT  = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Monitor: busy falling edge marks a result ready; SHIFT cycles consume bits.
  int   rise_cyc  = -1;
  logic busy_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t r;
    logic b;
    if (RST) begin
      busy_prev = 1'b0;
    end else begin
      if (ADCBUSY && !busy_prev) rise_cyc = cyc;
      if (!ADCBUSY && busy_prev) begin
        if (exp_q.size() == 0) begin
          chk("busy_unexpected", 32'(1), 32'(0));
        end else begin
          r = exp_q.pop_front();
          chk("busy_rise_edge", 32'(rise_cyc), 32'(r.rise));
          chk("busy_fall_edge", 32'(cyc), 32'(r.fall));
          chk("cnt_at_ready", 32'(CONV_CNT), 32'(r.cnt));
          chk("ovr_at_ready", 32'(OVR), 32'(r.ovr));
          chk("sdo_msb_at_ready", 32'(SDO), 32'(r.data[WIDTH-1]));
        end
      end
      if (SHIFT) begin
        if (bit_q.size() == 0) begin
          chk("sdo_bit_unexpected", 32'(1), 32'(0));
        end else begin
          b = bit_q.pop_front();
          chk("sdo_bit", 32'(SDO), 32'(b));
        end
      end
      busy_prev = ADCBUSY;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] w;
    logic [7:0]       cnt0;
    logic             lvl;
    int               t;

    // Reset values.
    RST = 1'b1;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_adcbusy", 32'(ADCBUSY), 32'(0));
    chk("rst_sdo", 32'(SDO), 32'(0));
    chk("rst_ovr", 32'(OVR), 32'(0));
    chk("rst_conv_cnt", 32'(CONV_CNT), 32'(0));
    RST = 1'b0;

    // Basic conversion and 12-bit readout.
    idle(3);
    tick(1'b1, 1'b0, 12'hA5C);
    idle(22);
    shifts(12);
    chk("basic_conv_cnt", 32'(CONV_CNT), 32'(m_cnt));
    shifts(2);

    // Held-high request converts once.
    cnt0 = CONV_CNT;
    for (int i = 0; i < 40; i++) tick(1'b1, 1'b0, 12'h3C1);
    idle(5);
    chk("held_conv_cnt", 32'(CONV_CNT), 32'(cnt0 + 8'd1));
    chk("held_ovr", 32'(OVR), 32'(0));
    shifts(12);

    // Overrun during Busy.
    tick(1'b1, 1'b0, 12'h5A3);
    idle(7);
    tick(1'b1, 1'b0, 12'hFFF);
    idle(20);
    chk("ovr_sticky", 32'(OVR), 32'(m_ovr));
    chk("ovr_cnt_unchanged", 32'(CONV_CNT), 32'(m_cnt));
    shifts(12);
    tick(1'b1, 1'b0, 12'h0F0);
    tick(1'b0, 1'b0, 12'h0F0);
    chk("ovr_cleared", 32'(OVR), 32'(m_ovr));
    idle(22);

    // Reset in the fifth Busy cycle.
    tick(1'b1, 1'b0, 12'h777);
    idle(7);
    chk("busy_before_rst", 32'(ADCBUSY), 32'(1));
    #1;
    RST = 1'b1;
    #1;
    chk("midrst_adcbusy", 32'(ADCBUSY), 32'(0));
    chk("midrst_sdo", 32'(SDO), 32'(0));
    chk("midrst_conv_cnt", 32'(CONV_CNT), 32'(0));
    chk("midrst_ovr", 32'(OVR), 32'(0));
    do_reset(1'b1);

    // BBCONV high across reset release is not a start.
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0, 12'h123);
    idle(25);
    chk("rst_high_conv_cnt", 32'(CONV_CNT), 32'(m_cnt));
    chk("rst_high_busy", 32'(ADCBUSY), 32'(0));

    // Start and SHIFT in the same Ready cycle, then 13 shifts.
    tick(1'b1, 1'b0, 12'h9B4);
    idle(22);
    shifts(3);
    tick(1'b1, 1'b1, 12'h6C5);
    idle(22);
    shifts(13);

    // Closed-loop controller: two conversions per request.
    for (int req = 0; req < 3; req++) begin
      cnt0 = CONV_CNT;
      for (int c = 0; c < 2; c++) begin
        s = WIDTH'($urandom);
        tick(1'b1, 1'b0, s);
        tick(1'b0, 1'b0, s);
        t = 0;
        while (!ADCBUSY && t < 50) begin tick(1'b0, 1'b0, s); t++; end
        chk("ctl_busy_seen", 32'(ADCBUSY), 32'(1));
        t = 0;
        while (ADCBUSY && t < 50) begin tick(1'b0, 1'b0, s); t++; end
        chk("ctl_busy_done", 32'(ADCBUSY), 32'(0));
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
          w = {w[WIDTH-2:0], SDO};
          tick(1'b0, 1'b1, s);
        end
        chk("ctl_word", 32'(w), 32'(s));
      end
      chk("ctl_cnt_step", 32'(CONV_CNT), 32'(cnt0 + 8'd2));
    end

    // Randomised traffic against the model.
    do_reset(1'b0);
    lvl = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) < 12) lvl = ~lvl;
      tick(lvl, ($urandom_range(0, 99) < 35), WIDTH'($urandom));
    end
    idle(30);
    chk("rand_conv_cnt", 32'(CONV_CNT), 32'(m_cnt));
    chk("rand_ovr", 32'(OVR), 32'(m_ovr));
    chk("exp_q_drained", 32'(exp_q.size()), 32'(0));
    chk("bit_q_drained", 32'(bit_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
